// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: round-robin between two writeback requesters, lockable bursts,
// one registered write stage and a hazard check. Define REGFILE_WR_ARB_BYPASS_EN to add read forwarding.
module regfile_wr_arb #(
    parameter int AW      = 3,
    parameter int DW      = 8,
    parameter int RR_INIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_lock,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_lock,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
`ifdef REGFILE_WR_ARB_BYPASS_EN
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic [DW-1:0] fwd_rdata1,
    output logic [DW-1:0] fwd_rdata2,
`endif
    input  logic [AW-1:0] chk_addr,
    output logic          chk_busy
);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    typedef struct packed {
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wreq_t;

    state_t state;
    logic   prio;
    logic   g0, g1, xfer;
    wreq_t  gsel;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        case (state)
            ARB: begin
                if (req0_valid && (!req1_valid || !prio)) g0 = 1'b1;
                else if (req1_valid)                      g1 = 1'b1;
            end
            LOCK0:   g0 = req0_valid;
            LOCK1:   g1 = req1_valid;
            default: ;
        endcase
        if (rst) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    assign req0_ready = g0;
    assign req1_ready = g1;
    assign xfer       = g0 | g1;
    assign gsel       = g1 ? wreq_t'{req1_lock, req1_addr, req1_data}
                           : wreq_t'{req0_lock, req0_addr, req0_data};

    // prio flips to the other side on every transfer; inside a lock it is
    // don't-care, and on lock exit it lands on the other requester as needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            prio     <= 1'(RR_INIT);
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer;
            if (xfer) begin
                rf_waddr <= gsel.addr;
                rf_wdata <= gsel.data;
                prio     <= g0;
                if (gsel.lock) state <= g0 ? LOCK0 : LOCK1;
                else           state <= ARB;
            end
        end
    end

    assign chk_busy = (rf_we && rf_waddr == chk_addr) || (xfer && gsel.addr == chk_addr);

`ifdef REGFILE_WR_ARB_BYPASS_EN
    assign fwd_rdata1 = (rf_we && rf_waddr == raddr1) ? rf_wdata : rf_rdata1;
    assign fwd_rdata2 = (rf_we && rf_waddr == raddr2) ? rf_wdata : rf_rdata2;
`endif

endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Shares the single register-file write port (we/waddr/wdata) between two writeback requesters: req0 (ALU writeback) and req1 (load/memory writeback).
- Round-robin arbitration with a multi-cycle lock for back-to-back burst writes.
- Registered write stage driving the regfile.
- Hazard-check output so decode can stall on registers with writes in flight.

Parameters:
- AW, 3: register address width (8 registers).
- DW, 8: data width.
- RR_INIT, 0: requester favoured by round-robin after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has a write pending
- req0_lock  in  1  requester 0 keeps the grant after this transfer
- req0_addr  in  AW  requester 0 destination register
- req0_data  in  DW  requester 0 write data
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid, req1_lock, req1_addr, req1_data, req1_ready: same as req0, for requester 1
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  AW  regfile write address (registered)
- rf_wdata  out  DW  regfile write data (registered)
- chk_addr  in  AW  register queried by decode
- chk_busy  out  1  a write to chk_addr is in flight

Behaviour:
- Transfer: a transfer on requester i happens at a posedge where reqi_valid=1 and reqi_ready=1. The requester holds valid, addr, data and lock stable until ready.
- reqi_ready is combinational from the FSM state, prio and both valids. It never depends on addr or data. At most one ready is high per cycle.
- FSM states: ARB, LOCK0, LOCK1. Reset state is ARB.
- ARB, one valid: grant that requester.
- ARB, both valid: grant the requester selected by prio.
- ARB, no valid: no grant.
- prio: after any transfer completes in ARB or on lock exit, prio points to the other requester. Reset value is RR_INIT.
- ARB transition: a transfer with lock=1 moves to LOCKi. A transfer with lock=0 stays in ARB.
- LOCKi: only requester i can be granted. The other requester's ready is held at 0 even if its valid=1.
- LOCKi exit: a transfer from i with lock=0 returns to ARB and prio points to the other requester.
- LOCKi with reqi_valid=0: stay in LOCKi with no grant. There is no timeout.
- Write stage: at a transfer edge, rf_we<=1, rf_waddr<=addr, rf_wdata<=data. Otherwise rf_we<=0 and rf_waddr/rf_wdata hold their values.
- Write timing: the regfile commits the write at the next posedge, so latency is 1 cycle from transfer to rf_we=1. Sustained throughput is 1 write per cycle.
- chk_busy = (rf_we && rf_waddr==chk_addr) || (a transfer this cycle && granted addr==chk_addr). It is purely combinational.
- Same-address writes: back-to-back writes to the same address are issued in acceptance order. No merging.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, req0_ready=0, req1_ready=0, state=ARB, prio=RR_INIT.
- Reset mid-operation: reset asserted during LOCKi or with rf_we=1 clears rf_we immediately (asynchronously), so the in-flight write is dropped. State returns to ARB and prio to RR_INIT. No ready is issued while rst=1.

Optional Feature:
- Macro name: REGFILE_WR_ARB_BYPASS_EN.
- When defined, extra ports are added:
  - raddr1 and raddr2, each in, AW wide.
  - rf_rdata1 and rf_rdata2, each in, DW wide, driven from the regfile read ports.
  - fwd_rdata1 and fwd_rdata2, each out, DW wide.
- Forwarding rule: fwd_rdataN = rf_wdata when rf_we=1 && rf_waddr==raddrN; otherwise rf_rdataN. This gives a write-then-read-same-cycle bypass. Combinational; no added latency.
- When not defined: the extra ports are absent, and read data comes straight from the regfile.

Test Plan:
- Single requester: req0 valid, addr=1, data=AA, lock=0 -> req0_ready=1 the same cycle. The next cycle gives rf_we=1, rf_waddr=1, rf_wdata=AA, and the cycle after gives rf_we=0.
- Round-robin: RR_INIT=0, both valid continuously (req0 addr=2/data=11, req1 addr=3/data=22) -> grants alternate 0,1,0,1. rf_waddr sequence is 2,3,2,3 with rf_we=1 every cycle.
- Lock burst: req1 valid with lock=1,1,0 writing addr 4,5,6 (data 01,02,03) while req0 is valid -> req0_ready=0 for all three cycles. The next grant goes to req0.
- Lock idle: in LOCK0 with req0_valid low for 3 cycles and req1 valid -> no ready and rf_we=0. req0 then returns with lock=0 and is granted.
- Hazard check: chk_addr=5 with req0 transferring addr=5 -> chk_busy=1 in the transfer cycle and in the following rf_we cycle, then 0. chk_addr=6 -> chk_busy stays 0.
- Reset mid-lock: assert rst while in LOCK1 with rf_we=1 -> rf_we=0 immediately. After rst deasserts, both valid gives the grant to RR_INIT. With REGFILE_WR_ARB_BYPASS_EN, rf_we=1/addr=1/data=AA and raddr1=1 -> fwd_rdata1=AA.
